// File: rtl/br_multi.sv
// -----------------------------------------------------------------------------
// br_multi -- multi-ported register file with a hardware clear sweep.
//
// Two combinational read ports and one synchronous write port. Register 0 is
// hard-wired to zero. A clear request, or reset, starts a sweep that zeroes
// registers 1..DEPTH-1, one per clock. Host writes that collide with a sweep
// are discarded and reported one cycle later on wr_drop.
//
// Optional feature: define BR_BYPASS_EN to forward same-cycle write data to a
// read port whose address matches the write address.
//
// Parameters:
//   WIDTH   data bits per register
//   DEPTH   number of registers (power of two, >= 4)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset; starts a clear sweep on release
//   a1, a2   read addresses, ports 1 and 2
//   a3       write address
//   wd3      write data
//   we3      write enable
//   clr      request a full clear sweep
//   rd1,rd2  read data, ports 1 and 2 (combinational)
//   busy     high while the clear sweep runs (and while rst_n is low)
//   done     one-cycle pulse after the last register is cleared
//   wr_drop  one-cycle pulse: the previous cycle's write was discarded
// -----------------------------------------------------------------------------
module br_multi #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we3,
  input  logic             clr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_CLEAR  = 1'b1;
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             wr_drop_q, wr_drop_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             host_wr_req;

  // Writes to register 0 are silently ignored, so they never count as drops.
  assign host_wr_req = we3 && (a3 != '0);

  // ---------------------------------------------------------------------------
  // Next-state and array write-port selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    wr_drop_d = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = a3;
    wr_data   = wd3;

    case (state_q)
      S_IDLE: begin
        if (clr) begin
          // Clear wins over a same-cycle write; the write is reported dropped.
          state_d   = S_CLEAR;
          idx_d     = AW'(1);
          wr_drop_d = host_wr_req;
        end else if (host_wr_req) begin
          wr_en = 1'b1;
        end
      end
      default: begin  // S_CLEAR: the sweep owns the write port
        wr_en     = 1'b1;
        wr_addr   = idx_q;
        wr_data   = '0;
        wr_drop_d = host_wr_req;
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers. Reset parks the FSM at the start of a sweep, so the
  // array is zeroed by the sweep after release rather than by reset itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      idx_q     <= AW'(1);
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // NOTE: the array has no reset branch; it is cleared by the sweep, which
  // keeps it mappable to plain RAM/flop arrays without a reset fan-out.
  // A write pending on the reset edge is simply lost.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] arr_rd1, arr_rd2;

  // Register 0 is never written, so it is forced to zero on the read side.
  assign arr_rd1 = (a1 == '0) ? '0 : mem_q[a1];
  assign arr_rd2 = (a2 == '0) ? '0 : mem_q[a2];

`ifdef BR_BYPASS_EN
  // Forward only when the write will really land on the next edge.
  logic fwd_ok;
  assign fwd_ok = (state_q == S_IDLE) && !clr && host_wr_req;
  assign rd1    = (fwd_ok && (a3 == a1)) ? wd3 : arr_rd1;
  assign rd2    = (fwd_ok && (a3 == a2)) ? wd3 : arr_rd2;
`else
  assign rd1 = arr_rd1;
  assign rd2 = arr_rd2;
`endif

  // busy also covers the reset interval itself, before the first reset edge.
  assign busy    = (state_q == S_CLEAR) || !rst_n;
  assign done    = done_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_br_multi.sv
// -----------------------------------------------------------------------------
// tb_br_multi -- self-checking bench for br_multi (WIDTH=32, DEPTH=32).
// Table-driven vectors for the basic read/write behaviour, hand-written
// sequences for sweep/reset corner cases, and a randomized phase compared
// against a behavioural model of the register file.
// -----------------------------------------------------------------------------
module tb_br_multi;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] a1, a2, a3;
  logic [W-1:0]  wd3;
  logic          we3, clr;
  logic [W-1:0]  rd1, rd2;
  logic          busy, done, wr_drop;

  int checks = 0;
  int errors = 0;

  br_multi #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .wd3    (wd3),
    .we3    (we3),
    .clr    (clr),
    .rd1    (rd1),
    .rd2    (rd2),
    .busy   (busy),
    .done   (done),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; clr = 1'b0; a3 = '0; wd3 = '0; a1 = '0; a2 = '0;
  endtask

  task automatic write_reg(input logic [AW-1:0] addr, input logic [W-1:0] data);
    we3 = 1'b1; a3 = addr; wd3 = data;
    tick();
    we3 = 1'b0;
  endtask

  // Count busy cycles until busy falls (bounded), plus done/wr_drop pulses seen
  // during the sweep and on the cycle after it.
  task automatic run_sweep(output int busy_cnt, output int done_cnt, output int drop_cnt);
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      busy_cnt++;
      tick();
      if (done)    done_cnt++;
      if (wr_drop) drop_cnt++;
    end
    tick();
    if (done)    done_cnt++;
    if (wr_drop) drop_cnt++;
  endtask

  task automatic reset_and_sweep(input string tag);
    int bc, dc, pc;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check({tag, "_busy_in_reset"}, W'(busy), 32'd1);
    check({tag, "_done_in_reset"}, W'(done), 32'd0);
    rst_n = 1'b1;
    run_sweep(bc, dc, pc);
    check({tag, "_busy_cycles"}, W'(bc), 32'd31);
    check({tag, "_done_pulses"}, W'(dc), 32'd1);
  endtask

  typedef struct {
    logic [AW-1:0] a1, a2, a3;
    logic [W-1:0]  wd3;
    logic          we3;
    logic [W-1:0]  exp_rd1, exp_rd2;
    logic          exp_drop;
  } vec_t;

  // Behavioural model for the random phase.
  logic [W-1:0] mdl_mem [D];
  bit           mdl_sweeping;
  int           mdl_next;

  function automatic logic [W-1:0] mdl_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef BR_BYPASS_EN
    if (!mdl_sweeping && we3 && !clr && a3 != 0 && a3 == a) return wd3;
`endif
    return mdl_mem[a];
  endfunction

  initial begin
    vec_t vecs[7];
    int bc, dc, pc;
    bit exp_done, exp_drop;

    idle_inputs();
    rst_n = 1'b0;

    // ---------------- reset sweep ----------------
    reset_and_sweep("rst");
    for (int i = 0; i < D; i += 7) begin
      a1 = AW'(i);
      #1;
      check($sformatf("rst_zero_r%0d", i), rd1, 32'd0);
    end

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{a1: 3, a2: 0, a3: 2, wd3: 32'hDEADBEEF, we3: 1, exp_rd1: 0,            exp_rd2: 0,            exp_drop: 0};
    vecs[1] = '{a1: 2, a2: 1, a3: 0, wd3: 32'h0,        we3: 0, exp_rd1: 32'hDEADBEEF, exp_rd2: 0,            exp_drop: 0};
    vecs[2] = '{a1: 0, a2: 2, a3: 0, wd3: 32'h12345678, we3: 1, exp_rd1: 0,            exp_rd2: 32'hDEADBEEF, exp_drop: 0};
    vecs[3] = '{a1: 0, a2: 0, a3: 0, wd3: 32'h0,        we3: 0, exp_rd1: 0,            exp_rd2: 0,            exp_drop: 0};
    vecs[4] = '{a1: 2, a2: 2, a3: 5, wd3: 32'hCAFEF00D, we3: 1, exp_rd1: 32'hDEADBEEF, exp_rd2: 32'hDEADBEEF, exp_drop: 0};
    vecs[5] = '{a1: 5, a2: 0, a3: 9, wd3: 32'h1,        we3: 1, exp_rd1: 32'hCAFEF00D, exp_rd2: 0,            exp_drop: 0};
    vecs[6] = '{a1: 9, a2: 5, a3: 0, wd3: 32'h0,        we3: 0, exp_rd1: 32'h1,        exp_rd2: 32'hCAFEF00D, exp_drop: 0};
    for (int i = 0; i < 7; i++) begin
      a1 = vecs[i].a1; a2 = vecs[i].a2; a3 = vecs[i].a3;
      wd3 = vecs[i].wd3; we3 = vecs[i].we3; clr = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp_rd2);
      check($sformatf("vec%0d_busy", i), W'(busy), 32'd0);
      tick();
      check($sformatf("vec%0d_drop", i), W'(wr_drop), W'(vecs[i].exp_drop));
    end
    idle_inputs();

    // ---------------- same-cycle write vs read (bypass) ----------------
    we3 = 1'b1; a3 = 9; a1 = 9; wd3 = 32'hA5A5A5A5;
    #1;
`ifdef BR_BYPASS_EN
    check("same_cycle_rd1", rd1, 32'hA5A5A5A5);
`else
    check("same_cycle_rd1", rd1, 32'h1);
`endif
    tick();
    we3 = 1'b0;
    #1;
    check("after_write_rd1", rd1, 32'hA5A5A5A5);

    // ---------------- clr with colliding write ----------------
    idle_inputs();
    clr = 1'b1; we3 = 1'b1; a3 = 7; wd3 = 32'h77777777;
    tick();
    idle_inputs();
    check("clr_drop_pulse", W'(wr_drop), 32'd1);
    check("clr_busy", W'(busy), 32'd1);
    run_sweep(bc, dc, pc);
    check("clr_busy_cycles", W'(bc), 32'd31);
    check("clr_done_pulses", W'(dc), 32'd1);
    check("clr_drop_once", W'(pc), 32'd0);
    a1 = 5; a2 = 7;
    #1;
    check("clr_reg5", rd1, 32'd0);
    check("clr_reg7", rd2, 32'd0);

    // ---------------- mid-sweep reads, clr ignored while sweeping ----------------
    write_reg(10, 32'hAAAA0010);
    write_reg(20, 32'hBBBB0020);
    clr = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      clr = (k < 3);
      tick();
    end
    clr = 1'b0; a1 = 10; a2 = 20;
    #1;
    check("mid_sweep_swept", rd1, 32'd0);
    check("mid_sweep_unswept", rd2, 32'hBBBB0020);
    run_sweep(bc, dc, pc);
    check("mid_sweep_remaining", W'(bc), 32'd19);
    check("mid_sweep_done", W'(dc), 32'd1);
    a2 = 20;
    #1;
    check("mid_sweep_final", rd2, 32'd0);

    // ---------------- reset mid-sweep ----------------
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dc++;
    end
    check("rst_mid_no_done", W'(dc), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", W'(busy), 32'd1);
    rst_n = 1'b1;
    run_sweep(bc, dc, pc);
    check("rst_mid_busy_cycles", W'(bc), 32'd31);
    check("rst_mid_done", W'(dc), 32'd1);

    // ---------------- reset during a write: no wr_drop ----------------
    write_reg(4, 32'h44444444);
    we3 = 1'b1; a3 = 4; wd3 = 32'h99999999; rst_n = 1'b0;
    tick();
    check("rst_write_no_drop", W'(wr_drop), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    run_sweep(bc, dc, pc);
    check("rst_write_drop_cnt", W'(pc), 32'd0);
    a1 = 4;
    #1;
    check("rst_write_reg4", rd1, 32'd0);

    // ---------------- randomized phase vs model ----------------
    for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    mdl_sweeping = 0;
    mdl_next = 1;
    for (int n = 0; n < 400; n++) begin
      a1  = AW'($urandom_range(0, D - 1));
      a2  = AW'($urandom_range(0, D - 1));
      a3  = AW'($urandom_range(0, D - 1));
      wd3 = $urandom;
      we3 = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      #1;
      check($sformatf("rnd%0d_rd1", n), rd1, mdl_read(a1));
      check($sformatf("rnd%0d_rd2", n), rd2, mdl_read(a2));
      check($sformatf("rnd%0d_busy", n), W'(busy), W'(mdl_sweeping));
      exp_done = 0;
      exp_drop = we3 && a3 != 0 && (mdl_sweeping || clr);
      if (mdl_sweeping) begin
        mdl_mem[mdl_next] = '0;
        mdl_next++;
        if (mdl_next == D) begin
          mdl_sweeping = 0;
          exp_done = 1;
        end
      end else if (clr) begin
        mdl_sweeping = 1;
        mdl_next = 1;
      end else if (we3 && a3 != 0) begin
        mdl_mem[a3] = wd3;
      end
      tick();
      check($sformatf("rnd%0d_done", n), W'(done), W'(exp_done));
      check($sformatf("rnd%0d_drop", n), W'(wr_drop), W'(exp_drop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
